// File: rtl/dff_pkg.sv
// Shared types for the universal shift register.
// Op codes, FSM states and shift direction.
package dff_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_CLEAR = 3'b010,
    OP_RSVD  = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHR   = 3'b101,
    OP_ROTL  = 3'b110,
    OP_ROTR  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/dff_delay_line.sv
// DEPTH-stage push-enabled delay line.
// dout is the oldest stage.
module dff_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= '0;
    end else if (push) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dff_universal_shreg.sv
// Command-driven universal shift register
// with busy/done handshake and commit history.
module dff_universal_shreg #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hist_q
);

  import dff_pkg::*;

  logic [WIDTH-1:0] q_q, q_d;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  op_e              op_in;
  logic             accept;

  function automatic logic [WIDTH-1:0] step(
    input op_e              op,
    input logic [WIDTH-1:0] v,
    input logic             s
  );
    case (op)
      OP_SHL:  step = {v[WIDTH-2:0], s};
      OP_SHR:  step = {s, v[WIDTH-1:1]};
      OP_ROTL: step = {v[WIDTH-2:0], v[WIDTH-1]};
      default: step = {v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  assign op_in  = op_e'(cmd_op);
  assign accept = ena & cmd_valid & (state_q == IDLE);

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    dir_d   = dir_q;
    op_d    = op_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (accept) begin
      unique case (op_in)
        OP_LOAD: begin
          q_d    = d;
          done_d = 1'b1;
        end
        OP_CLEAR: begin
          q_d    = RESET_VAL;
          done_d = 1'b1;
        end
        OP_SHL, OP_SHR, OP_ROTL, OP_ROTR: begin
          if (cmd_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            op_d    = op_in;
            rem_d   = cmd_cnt;
            state_d = RUN;
            dir_d   = (op_in == OP_SHL ||
                       op_in == OP_ROTL) ? LEFT : RIGHT;
          end
        end
        default: done_d = 1'b1;
      endcase
    end else if (ena && state_q == RUN) begin
      q_d   = step(op_q, q_q, sin);
      rem_d = rem_q - CNT_W'(1);
      // Final shift lands on the rem 1->0 edge.
      if (rem_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= RESET_VAL;
      state_q <= IDLE;
      dir_q   <= LEFT;
      op_q    <= OP_NOP;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  dff_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_hist (
    .clk  (clk),
    .rst  (rst),
    .push (done_d),
    .din  (q_d),
    .dout (hist_q)
  );

  assign q         = q_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign cmd_ready = (state_q == IDLE);
  assign sout      = (dir_q == LEFT) ? q_q[WIDTH-1]
                                     : q_q[0];

endmodule

// File: tb/tb_dff_universal_shreg.sv
// Scoreboard bench for dff_universal_shreg.
// Busy and done samples are checked against queued expectations.
module tb_dff_universal_shreg;

  logic       clk = 1'b0;
  logic       rst, ena, cmd_valid, sin;
  logic       cmd_ready, sout, busy, done;
  logic [2:0] cmd_op;
  logic [4:0] cmd_cnt;
  logic [7:0] d, q, hist_q;

  typedef struct {
    logic [7:0] q;
    logic       s;
  } busy_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] h;
  } done_t;

  busy_t bq[$];
  done_t dq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  dff_universal_shreg #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .d         (d),
    .sin       (sin),
    .q         (q),
    .sout      (sout),
    .busy      (busy),
    .done      (done),
    .hist_q    (hist_q)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic exp_busy(input logic [7:0] eq,
                          input logic es);
    busy_t b;
    b.q = eq;
    b.s = es;
    bq.push_back(b);
  endtask

  task automatic exp_done(input logic [7:0] eq,
                          input logic [7:0] eh);
    done_t e;
    e.q = eq;
    e.h = eh;
    dq.push_back(e);
  endtask

  always @(negedge clk) begin
    busy_t b;
    if (busy === 1'b1) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL busy_unexpected act=%h exp=none", q);
      end else begin
        b = bq.pop_front();
        check("busy_q", q, b.q);
        check("busy_sout", sout, b.s);
      end
    end
  end

  always @(negedge clk) begin
    done_t e;
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected act=%h exp=none", q);
      end else begin
        e = dq.pop_front();
        check("done_q", q, e.q);
        check("done_hist", hist_q, e.h);
      end
    end
  end

  task automatic cmd(input logic [2:0] op,
                     input logic [4:0] cnt,
                     input logic [7:0] data);
    cmd_op    = op;
    cmd_cnt   = cnt;
    d         = data;
    cmd_valid = 1'b1;
    @(posedge clk) #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act=nodone exp=done", name);
    end
    @(posedge clk) #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_cnt   = '0;
    d         = '0;
    sin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_hist", hist_q, 8'h00);
    check("rst_sout", sout, 1'b0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(posedge clk) #1;

    exp_done(8'hA5, 8'h00);
    cmd(3'b001, 5'd0, 8'hA5);
    wait_done("load");

    exp_busy(8'hA5, 1'b1);
    exp_busy(8'h4B, 1'b0);
    exp_busy(8'h96, 1'b1);
    exp_done(8'h2D, 8'h00);
    cmd(3'b110, 5'd3, 8'h00);
    wait_done("rotl");

    sin = 1'b1;
    exp_busy(8'h2D, 1'b1);
    exp_busy(8'h96, 1'b0);
    exp_busy(8'hCB, 1'b1);
    exp_busy(8'hE5, 1'b1);
    exp_done(8'hF2, 8'h00);
    cmd(3'b101, 5'd4, 8'h00);
    wait_done("shr");

    exp_done(8'hF2, 8'hA5);
    cmd(3'b100, 5'd0, 8'h00);
    wait_done("shl0");

    exp_done(8'h01, 8'h2D);
    cmd(3'b001, 5'd0, 8'h01);
    wait_done("load01");

    exp_busy(8'h01, 1'b1);
    repeat (4) exp_busy(8'h80, 1'b0);
    exp_done(8'h40, 8'hF2);
    cmd_op    = 3'b111;
    cmd_cnt   = 5'd2;
    cmd_valid = 1'b1;
    @(posedge clk) #1;
    cmd_op = 3'b001;
    d      = 8'hFF;
    @(posedge clk) #1;
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    wait_done("rotr");

    exp_busy(8'h40, 1'b0);
    exp_busy(8'h81, 1'b1);
    exp_busy(8'h03, 1'b0);
    cmd(3'b100, 5'd5, 8'h00);
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_q", q, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_hist", hist_q, 8'h00);
    repeat (6) @(posedge clk);
    #1;

    exp_done(8'h11, 8'h00);
    cmd(3'b001, 5'd0, 8'h11);
    wait_done("h1");
    exp_done(8'h22, 8'h00);
    cmd(3'b001, 5'd0, 8'h22);
    wait_done("h2");
    exp_done(8'h33, 8'h00);
    cmd(3'b001, 5'd0, 8'h33);
    wait_done("h3");
    exp_done(8'h44, 8'h11);
    cmd(3'b001, 5'd0, 8'h44);
    wait_done("h4");
    exp_done(8'h55, 8'h22);
    cmd(3'b001, 5'd0, 8'h55);
    wait_done("h5");
    repeat (3) @(posedge clk);
    #1;

    check("busy_queue_left", bq.size(), 0);
    check("done_queue_left", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
